// File: rtl/nec_ir_rx.sv
// NEC / extended-NEC IR frame receiver: synchroniser, glitch filter, 1 us pulse timer, decode FSM, valid/ready output.
// Define NEC_IR_RX_REPEAT_EN to replay the last good frame on a repeat code.
module nec_ir_rx #(
    parameter int CLK_HZ     = 25000000,
    parameter int TOL_PCT    = 25,
    parameter int FRAME_BITS = 32,
    parameter int INVERT     = 1,
    parameter int FILT_CYC   = 16,
    parameter int CHECK_CMD  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  ir_in,
    output logic                  valid,
    input  logic                  ready,
    output logic [FRAME_BITS-1:0] data,
    output logic                  repeat_flag,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [3:0]            state_dbg
);

    localparam int DIV = (CLK_HZ / 1000000 < 1) ? 1 : CLK_HZ / 1000000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW  = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam int IW  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic IDLE_LVL = (INVERT != 0);
    localparam logic [13:0] CNT_MAX = 14'h3fff;

    function automatic logic [13:0] win_lo(input int nom);
        return 14'(nom * (100 - TOL_PCT) / 100);
    endfunction

    function automatic logic [13:0] win_hi(input int nom);
        return 14'(nom * (100 + TOL_PCT) / 100);
    endfunction

    localparam logic [13:0] LM_LO = win_lo(9000), LM_HI = win_hi(9000);
    localparam logic [13:0] LS_LO = win_lo(4500), LS_HI = win_hi(4500);
    localparam logic [13:0] RS_LO = win_lo(2250), RS_HI = win_hi(2250);
    localparam logic [13:0] BT_LO = win_lo(562),  BT_HI = win_hi(562);
    localparam logic [13:0] ON_LO = win_lo(1687), ON_HI = win_hi(1687);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LEAD_MARK  = 4'd1,
        S_LEAD_SPACE = 4'd2,
        S_BIT_MARK   = 4'd3,
        S_BIT_SPACE  = 4'd4,
        S_STOP_MARK  = 4'd5,
        S_REP_MARK   = 4'd6,
        S_DONE       = 4'd7
    } state_t;

    logic [1:0]      sync;
    logic            filt, filt_q;
    logic [FW-1:0]   fcnt;
    logic [PW-1:0]   pcnt;
    logic [13:0]     pulse;
    logic            tick, edge_det, mark_rise, mark_fall, sat;
    logic            w_lm, w_ls, w_rs, w_bt, w_on, chk_ok;
    state_t          state;
    logic [FRAME_BITS-1:0] shreg;
    logic [IW-1:0]   idx;
    logic            rep_frm;

    // Idle reset level keeps the filter from reporting a phantom mark after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync   <= {2{IDLE_LVL}};
            filt   <= IDLE_LVL;
            filt_q <= IDLE_LVL;
            fcnt   <= '0;
        end else begin
            sync   <= {sync[0], ir_in};
            filt_q <= filt;
            if (sync[1] == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILT_CYC - 1)) begin
                filt <= sync[1];
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign edge_det  = (filt != filt_q);
    assign mark_rise = edge_det & (filt ^ IDLE_LVL);
    assign mark_fall = edge_det & ~(filt ^ IDLE_LVL);
    assign tick      = (DIV == 1) || (pcnt == PW'(DIV - 1));
    assign sat       = (pulse == CNT_MAX);

    // Restart at 1 when the edge coincides with a tick so the count equals the pulse length in us.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt  <= '0;
            pulse <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (edge_det)
                pulse <= {13'd0, tick};
            else if (tick && !sat)
                pulse <= pulse + 1'b1;
        end
    end

    assign w_lm = (pulse >= LM_LO) && (pulse <= LM_HI);
    assign w_ls = (pulse >= LS_LO) && (pulse <= LS_HI);
    assign w_rs = (pulse >= RS_LO) && (pulse <= RS_HI);
    assign w_bt = (pulse >= BT_LO) && (pulse <= BT_HI);
    assign w_on = (pulse >= ON_LO) && (pulse <= ON_HI);

    if (CHECK_CMD != 0 && FRAME_BITS == 32) begin : g_chk
        assign chk_ok = (shreg[31:24] == ~shreg[23:16]);
    end else begin : g_nochk
        assign chk_ok = 1'b1;
    end

`ifdef NEC_IR_RX_REPEAT_EN
    logic [FRAME_BITS-1:0] last_frm;
    logic                  have_last;
    logic                  rep_q;
    assign repeat_flag = rep_q;
`else
    assign repeat_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            shreg     <= '0;
            idx       <= '0;
            rep_frm   <= 1'b0;
            valid     <= 1'b0;
            data      <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef NEC_IR_RX_REPEAT_EN
            last_frm  <= '0;
            have_last <= 1'b0;
            rep_q     <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready)
                valid <= 1'b0;
            if (!enable) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (mark_rise) state <= S_LEAD_MARK;
                    S_LEAD_MARK: if (mark_fall) state <= w_lm ? S_LEAD_SPACE : S_IDLE;
                    S_LEAD_SPACE: begin
                        if (mark_rise) begin
                            if (w_ls) begin
                                state   <= S_BIT_MARK;
                                idx     <= '0;
                                shreg   <= '0;
                                rep_frm <= 1'b0;
                            end else if (w_rs) begin
                                state   <= S_REP_MARK;
                                rep_frm <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else if (sat) begin
                            state <= S_IDLE;
                        end
                    end
                    S_BIT_MARK: begin
                        if ((mark_fall && !w_bt) || (!mark_fall && sat)) begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end else if (mark_fall) begin
                            state <= S_BIT_SPACE;
                        end
                    end
                    S_BIT_SPACE: begin
                        if ((mark_rise && !w_bt && !w_on) || (!mark_rise && sat)) begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end else if (mark_rise) begin
                            shreg[idx] <= w_on;
                            idx        <= idx + 1'b1;
                            state      <= (idx == IW'(FRAME_BITS - 1)) ? S_STOP_MARK : S_BIT_MARK;
                        end
                    end
                    S_STOP_MARK, S_REP_MARK: begin
                        if ((mark_fall && !w_bt) || (!mark_fall && sat)) begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end else if (mark_fall) begin
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        if (!rep_frm) begin
                            if (!chk_ok) begin
                                frame_err <= 1'b1;
                            end else begin
`ifdef NEC_IR_RX_REPEAT_EN
                                last_frm  <= shreg;
                                have_last <= 1'b1;
`endif
                                // An un-acked frame is kept; the newcomer is dropped and reported.
                                if (!valid || ready) begin
                                    valid <= 1'b1;
                                    data  <= shreg;
`ifdef NEC_IR_RX_REPEAT_EN
                                    rep_q <= 1'b0;
`endif
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end
                        end
`ifdef NEC_IR_RX_REPEAT_EN
                        else if (have_last) begin
                            if (!valid || ready) begin
                                valid <= 1'b1;
                                data  <= last_frm;
                                rep_q <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
`endif
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule
